// File: rtl/seg_pkg.sv
// Shared display constants and types for the segment scan path.
// Segment constants are also used by the BCD-to-7-seg decoders.
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_N  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned PCNT_W = 16;
    localparam int unsigned BCNT_W = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_ALL   = 7'b1111111;
    localparam logic [DIG_N-1:0] DIG_OFF   = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Registered display payload driven onto the shared bus.
    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic             dp;
        logic [DIG_N-1:0] dig_sel;
    } disp_out_t;

    localparam disp_out_t OUT_BLANK = '{seg: SEG_BLANK, dp: 1'b0, dig_sel: DIG_OFF};

    // Active-low enable pattern with only digit idx selected.
    function automatic logic [DIG_N-1:0] dig_enable_n(input logic [IDX_W-1:0] idx);
        logic [DIG_N-1:0] d;
        d      = DIG_OFF;
        d[idx] = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display bus for seg_scan_mux.
//   en, lamp_test, seg0..seg3, dp_in : from the time counters / control
//   seg_out, dp_out, dig_sel         : to the multiplexed display
interface seg_scan_mux_if;
    import seg_pkg::*;

    logic             en;
    logic             lamp_test;
    logic [SEG_W-1:0] seg0;
    logic [SEG_W-1:0] seg1;
    logic [SEG_W-1:0] seg2;
    logic [SEG_W-1:0] seg3;
    logic [DIG_N-1:0] dp_in;
    logic [SEG_W-1:0] seg_out;
    logic             dp_out;
    logic [DIG_N-1:0] dig_sel;

    modport master (
        output en, lamp_test, seg0, seg1, seg2, seg3, dp_in,
        input  seg_out, dp_out, dig_sel
    );

    modport slave (
        input  en, lamp_test, seg0, seg1, seg2, seg3, dp_in,
        output seg_out, dp_out, dig_sel
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Modulo-N counter with synchronous clear and count enable.
//   clk, clr (async active-low) : clock / reset
//   inc                         : advance the count this cycle
//   sclr                        : synchronous clear
//   tc_c                        : terminal count (count == N-1), combinational
module scan_tick_gen #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic sclr,
    output logic tc_c
);

    logic [W-1:0] cnt;

    assign tc_c = (cnt == W'(N - 1));

    // Count wraps to zero on the terminal value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (sclr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes four 7-segment digits onto one shared segment bus with
// a dark gap between digits, lamp test and display enable.
//   clk, clr (async active-low) : clock / reset
//   bus.en, bus.lamp_test       : display enable / all-segments test
//   bus.seg0..seg3, bus.dp_in   : digit codes and decimal-point requests
//   bus.seg_out, bus.dp_out     : shared segment bus and dp line (registered)
//   bus.dig_sel                 : active-low digit enables (registered)
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic           clk,
    input  logic           clr,
    seg_scan_mux_if.slave  bus
);

    scan_state_e      state;
    scan_state_e      state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             p_tc_c;
    logic             b_tc_c;
    logic             p_inc_c;
    logic             b_inc_c;
    disp_out_t        out_q;
    disp_out_t        out_nxt;
    logic             load_c;
    logic [IDX_W-1:0] load_idx;
    logic [SEG_W-1:0] seg_pick;

    assign p_inc_c = bus.en && (state == SHOW);
    assign b_inc_c = bus.en && (state == BLANK);

    // Lit-time prescaler.
    scan_tick_gen #(.N(DIV), .W(PCNT_W)) u_pcnt (
        .clk  (clk),
        .clr  (clr),
        .inc  (p_inc_c),
        .sclr (1'b0),
        .tc_c (p_tc_c)
    );

    // Dark-gap counter.
    scan_tick_gen #(.N(BLANK_CYC), .W(BCNT_W)) u_bcnt (
        .clk  (clk),
        .clr  (clr),
        .inc  (b_inc_c),
        .sclr (1'b0),
        .tc_c (b_tc_c)
    );

    // State and digit index registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= BLANK;
            idx   <= IDX_W'(3);
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state: everything holds while the display is disabled.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (bus.en) begin
            case (state)
                BLANK: begin
                    if (b_tc_c) begin
                        state_nxt = SHOW;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
                SHOW: begin
                    if (p_tc_c) begin
                        state_nxt = BLANK;
                    end
                end
                default: state_nxt = BLANK;
            endcase
        end
    end

    // Output values. Data is snapshotted only when a digit goes from dark to
    // lit: at SHOW entry, or on the first enabled edge after a mid-SHOW
    // disable (seen as a dark bus while still in SHOW).
    always_comb begin
        out_nxt  = out_q;
        load_c   = 1'b0;
        load_idx = idx;
        seg_pick = SEG_BLANK;
        if (!bus.en) begin
            out_nxt = OUT_BLANK;
        end else begin
            case (state)
                BLANK: begin
                    if (b_tc_c) begin
                        load_c   = 1'b1;
                        load_idx = idx_nxt;
                    end else begin
                        out_nxt = OUT_BLANK;
                    end
                end
                SHOW: begin
                    if (p_tc_c) begin
                        out_nxt = OUT_BLANK;
                    end else if (out_q.dig_sel == DIG_OFF) begin
                        load_c = 1'b1;
                    end
                end
                default: out_nxt = OUT_BLANK;
            endcase
        end

        case (load_idx)
            2'd0:    seg_pick = bus.seg0;
            2'd1:    seg_pick = bus.seg1;
            2'd2:    seg_pick = bus.seg2;
            default: seg_pick = bus.seg3;
        endcase

        if (load_c) begin
            out_nxt.seg     = bus.lamp_test ? SEG_ALL : seg_pick;
            out_nxt.dp      = bus.lamp_test | bus.dp_in[load_idx];
            out_nxt.dig_sel = dig_enable_n(load_idx);
        end
    end

    // Output registers; reset darkens the display without a clock.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_q <= OUT_BLANK;
        end else begin
            out_q <= out_nxt;
        end
    end

    assign bus.seg_out = out_q.seg;
    assign bus.dp_out  = out_q.dp;
    assign bus.dig_sel = out_q.dig_sel;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    localparam int D      = 4;
    localparam int B      = 2;
    localparam int SLOT   = D + B;
    localparam int PERIOD = 4 * SLOT;

    logic clk = 1'b0;
    logic clr = 1'b0;

    seg_scan_mux_if bus ();

    seg_scan_mux #(.DIV(D), .BLANK_CYC(B)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: t is the position in the scan counted in enabled
    // edges since reset. Within each slot of D+B positions the first B are
    // dark and the rest lit for digit (t / SLOT) % 4. Data is captured when
    // the display turns from dark to lit.
    int         t     = 0;
    bit         m_lit = 1'b0;
    int         m_dig = 0;
    logic [6:0] m_seg = 7'b0;
    logic       m_dp  = 1'b0;

    function automatic logic [6:0] pick_seg(input int d);
        case (d)
            0:       return bus.seg0;
            1:       return bus.seg1;
            2:       return bus.seg2;
            default: return bus.seg3;
        endcase
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            t     = 0;
            m_lit = 1'b0;
        end else if (!bus.en) begin
            m_lit = 1'b0;
        end else begin
            t     = (t + 1) % PERIOD;
            m_dig = (t / SLOT) % 4;
            if ((t % SLOT) >= B) begin
                if (!m_lit) begin
                    m_seg = bus.lamp_test ? 7'h7f : pick_seg(m_dig);
                    m_dp  = bus.lamp_test | bus.dp_in[m_dig];
                end
                m_lit = 1'b1;
            end else begin
                m_lit = 1'b0;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (clr) begin
            logic [3:0] e_dig;
            e_dig = m_lit ? ~(4'b0001 << m_dig) : 4'b1111;
            check_eq("dig_sel", bus.dig_sel, e_dig);
            check_eq("seg_out", bus.seg_out, m_lit ? m_seg : 7'b0);
            check_eq("dp_out", bus.dp_out, m_lit ? m_dp : 1'b0);
            check_eq("one_low", ($countones(~bus.dig_sel) <= 1), 1);
        end
    end

    task automatic wait_dig(input logic [3:0] target);
        int n = 0;
        while (bus.dig_sel !== target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("wait_dig", (n < 200), 1);
    endtask

    // Counts edges from reset release until the first digit lights.
    task automatic check_first_lit();
        int n = 0;
        bit seen = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        while (!seen && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.dig_sel !== 4'b1111) seen = 1'b1;
        end
        check_eq("first_lit_edge", n, B);
        check_eq("first_lit_dig", bus.dig_sel, 4'b1110);
    endtask

    initial begin
        bus.en        = 1'b1;
        bus.lamp_test = 1'b0;
        bus.seg0      = 7'b1111110;
        bus.seg1      = 7'b0110000;
        bus.seg2      = 7'b1101101;
        bus.seg3      = 7'b1011011;
        bus.dp_in     = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dig_sel", bus.dig_sel, 4'b1111);
        check_eq("rst_seg_out", bus.seg_out, 7'b0);
        check_eq("rst_dp_out", bus.dp_out, 1'b0);

        // Basic scan order and per-digit data over two full scans.
        check_first_lit();
        repeat (2 * PERIOD) @(posedge clk);

        // Input change mid-slot must not disturb the lit digit.
        wait_dig(4'b1110);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.seg0 = 7'b0110000;
        repeat (PERIOD + 2) @(posedge clk);

        // Display disable during digit 2.
        wait_dig(4'b1011);
        @(negedge clk);
        bus.en = 1'b0;
        repeat (5) @(negedge clk);
        bus.en = 1'b1;
        repeat (PERIOD) @(posedge clk);

        // Lamp test, then decimal point on digit 2 only.
        @(negedge clk);
        bus.dp_in     = 4'b0100;
        bus.lamp_test = 1'b1;
        repeat (PERIOD + 4) @(posedge clk);
        @(negedge clk);
        bus.lamp_test = 1'b0;
        repeat (PERIOD + 4) @(posedge clk);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.seg0 = 7'($urandom);
            if ($urandom_range(0, 3) == 0) bus.seg1 = 7'($urandom);
            if ($urandom_range(0, 3) == 0) bus.seg2 = 7'($urandom);
            if ($urandom_range(0, 3) == 0) bus.seg3 = 7'($urandom);
            if ($urandom_range(0, 7) == 0) bus.dp_in = 4'($urandom);
            bus.en        = ($urandom_range(0, 7) != 0);
            bus.lamp_test = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        bus.en        = 1'b1;
        bus.lamp_test = 1'b0;

        // Asynchronous reset between edges during digit 1.
        wait_dig(4'b1101);
        #2;
        clr = 1'b0;
        #1;
        check_eq("async_dig_sel", bus.dig_sel, 4'b1111);
        check_eq("async_seg_out", bus.seg_out, 7'b0);
        check_eq("async_dp_out", bus.dp_out, 1'b0);
        check_first_lit();
        repeat (PERIOD + 3) @(posedge clk);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
